// File: rtl/windower_stream.sv
// rtl/windower_stream.sv - streaming 1-D sliding-window generator with stride, same/valid framing and frame flags
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_vld     input sample valid
//   in_rdy     block can accept a sample (low in FLUSH/CLEAR, while a window is stalled, and in reset)
//   data_in    sample, NO_CH*DATA_W bits
//   out_vld    window valid
//   out_rdy    downstream accepts the window
//   data_out   WINDOW_SIZE taps, tap 0 is the newest sample
//   out_first  window is the first of its frame
//   out_last   window is the last of its frame
module windower_stream #(
   parameter int NO_CH       = 2,
   parameter int DATA_W      = 1,
   parameter int IMG_LEN     = 1024,
   parameter int WINDOW_SIZE = 3,
   parameter int STRIDE      = 1,
   parameter int PAD_EN      = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_vld,
   output logic                    in_rdy,
   input  logic [NO_CH*DATA_W-1:0] data_in,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic [NO_CH*DATA_W-1:0] data_out [WINDOW_SIZE-1:0],
   output logic                    out_first,
   output logic                    out_last
);

   localparam int SW    = NO_CH * DATA_W;
   localparam int PAD   = (PAD_EN != 0) ? (WINDOW_SIZE - 1) / 2 : 0;
   localparam int POS_W = $clog2(IMG_LEN + PAD + 1);
   localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam int OC_W  = $clog2(IMG_LEN + 1);
   localparam int TOTAL = (PAD_EN != 0) ? (IMG_LEN - 1) / STRIDE + 1
                                        : (IMG_LEN - WINDOW_SIZE) / STRIDE + 1;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [SW-1:0]     win [WINDOW_SIZE-1:0];
   logic [POS_W-1:0]  pos;     // shifts already performed in this frame
   logic [PH_W-1:0]   phase;
   logic [OC_W-1:0]   ocnt;
   logic              adv_ok;
   logic              shift;
   logic              clear_go;
   logic              elig;
   logic              emit;
   logic [SW-1:0]     shift_data;

   // A pending window blocks every shift, which keeps data_out stable under backpressure.
   assign adv_ok   = !out_vld || out_rdy;
   assign data_out = win;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; pos holds the index of the shift happening this cycle
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (shift && int'(pos) == IMG_LEN - 1) begin
               state_nxt = (PAD > 0) ? FLUSH : CLEAR;
            end
         end
         FLUSH: begin
            if (shift && int'(pos) == IMG_LEN + PAD - 1) begin
               state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            if (adv_ok) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // Output / control decode
   always_comb begin
      in_rdy     = 1'b0;
      shift      = 1'b0;
      clear_go   = 1'b0;
      shift_data = '0;
      case (state)
         RUN: begin
            in_rdy     = adv_ok && rst_n;
            shift      = in_vld && adv_ok && rst_n;
            shift_data = data_in;
         end
         FLUSH: begin
            shift = adv_ok;   // zero taps shifted in for the trailing padding
         end
         CLEAR: begin
            clear_go = adv_ok;
         end
         default: begin
            in_rdy = 1'b0;
         end
      endcase
   end

   // A shift is eligible once the window covers a legal output position.
   always_comb begin
      if (PAD_EN != 0) begin
         elig = int'(pos) >= PAD;
      end else begin
         elig = (int'(pos) >= WINDOW_SIZE - 1) && (int'(pos) <= IMG_LEN - 1);
      end
      // phase is zero at the first eligible shift because CLEAR/reset leave it there
      emit = shift && elig && (phase == '0);
   end

   // Datapath: window shift register, counters and output flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < WINDOW_SIZE; k++) begin
            win[k] <= '0;
         end
         pos       <= '0;
         phase     <= '0;
         ocnt      <= '0;
         out_vld   <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         if (clear_go) begin
            // Wipe the window so nothing from this frame reaches the next one.
            for (int k = 0; k < WINDOW_SIZE; k++) begin
               win[k] <= '0;
            end
            pos   <= '0;
            phase <= '0;
            ocnt  <= '0;
         end else if (shift) begin
            win[0] <= shift_data;
            for (int k = 1; k < WINDOW_SIZE; k++) begin
               win[k] <= win[k-1];
            end
            pos <= pos + POS_W'(1);
            if (elig) begin
               phase <= (phase == PH_W'(STRIDE - 1)) ? '0 : phase + PH_W'(1);
            end
         end

         if (emit) begin
            out_vld   <= 1'b1;
            out_first <= (ocnt == '0);
            out_last  <= (ocnt == OC_W'(TOTAL - 1));
            ocnt      <= ocnt + OC_W'(1);
         end else if (out_rdy) begin
            out_vld   <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_windower_stream.sv
// tb/tb_windower_stream.sv - self-checking bench for windower_stream (same S=1, same S=2, valid S=1)
module tb_windower_stream;

   localparam int N  = 8;
   localparam int W  = 3;
   localparam int SW = 8;

   typedef struct packed {
      logic [W*SW-1:0] taps;
      logic            first;
      logic            last;
   } win_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_vld    [3];
   logic            in_rdy    [3];
   logic [SW-1:0]   data_in   [3];
   logic            out_vld   [3];
   logic            out_rdy   [3];
   logic            out_first [3];
   logic            out_last  [3];
   logic [W*SW-1:0] dout      [3];

   int   n_cmp = 0;
   int   n_bad = 0;
   win_t exp_q[$];
   win_t got_q[$];

   always #5 clk = ~clk;

   // Instance 0: same S=1, instance 1: same S=2, instance 2: valid S=1
   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [SW-1:0] d [W-1:0];
      windower_stream #(
         .NO_CH(2), .DATA_W(4), .IMG_LEN(N), .WINDOW_SIZE(W),
         .STRIDE(g == 1 ? 2 : 1), .PAD_EN(g == 2 ? 0 : 1)
      ) u_dut (
         .clk(clk), .rst_n(rst_n),
         .in_vld(in_vld[g]), .in_rdy(in_rdy[g]), .data_in(data_in[g]),
         .out_vld(out_vld[g]), .out_rdy(out_rdy[g]), .data_out(d),
         .out_first(out_first[g]), .out_last(out_last[g])
      );
      assign dout[g] = {d[2], d[1], d[0]};
   end

   // Reference: enumerate output positions per frame and read taps from the sample array.
   task automatic build_exp(input int g, input logic [SW-1:0] xs[$]);
      int   pad  = (g == 2) ? 0 : (W - 1) / 2;
      int   s    = (g == 1) ? 2 : 1;
      int   lim  = (g == 2) ? N - W : N - 1;
      int   nf   = xs.size() / N;
      win_t e;
      exp_q.delete();
      for (int f = 0; f < nf; f++) begin
         for (int p = 0; p <= lim; p += s) begin
            int newest = (g == 2) ? p + W - 1 : p + pad;
            e.taps = '0;
            for (int k = 0; k < W; k++) begin
               int j = newest - k;
               if (j >= 0 && j < N) e.taps[k*SW +: SW] = xs[f*N + j];
            end
            e.first = (p == 0);
            e.last  = (p + s > lim);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic run_stream(input int g, input logic [SW-1:0] xs[$], input bit rnd_vld,
                             input bit rnd_rdy, input int stall_at, input int stall_len,
                             input bit chk_gap, input string nm);
      int   pad  = (g == 2) ? 0 : (W - 1) / 2;
      int   trig = (g == 2) ? W - 1 : pad;
      int   idx = 0, cyc = 0, acc_cyc = -1, first_cyc = -1, stall_left = 0, gap = 0;
      bit   gap_on = 0, stall_done = 0, hold = 0;
      win_t cur, prev;
      build_exp(g, xs);
      got_q.delete();
      prev = '0;
      while ((idx < xs.size() || got_q.size() < exp_q.size() || gap_on) && cyc < 2000) begin
         if (stall_at >= 0 && !stall_done && got_q.size() == stall_at && out_vld[g]) begin
            stall_left = stall_len;
            stall_done = 1;
         end
         if (stall_left > 0) begin
            out_rdy[g] = 1'b0;
            stall_left--;
         end else begin
            out_rdy[g] = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
         if (idx < xs.size() && (!rnd_vld || $urandom_range(0, 3) != 0)) begin
            in_vld[g]  = 1'b1;
            data_in[g] = xs[idx];
         end else begin
            in_vld[g]  = 1'b0;
            data_in[g] = SW'($urandom);
         end
         #1;
         cur.taps  = dout[g];
         cur.first = out_first[g];
         cur.last  = out_last[g];
         if (hold) begin
            n_cmp++;
            if (out_vld[g] !== 1'b1 || cur !== prev) begin
               n_bad++;
               $display("FAIL %s hold: got vld=%b win=%h want vld=1 win=%h", nm, out_vld[g], cur, prev);
            end
         end
         if (out_vld[g] && !out_rdy[g]) begin
            n_cmp++;
            if (in_rdy[g] !== 1'b0) begin
               n_bad++;
               $display("FAIL %s in_rdy_stall: got %b want 0", nm, in_rdy[g]);
            end
         end
         hold = out_vld[g] && !out_rdy[g];
         prev = cur;
         if (out_vld[g] && first_cyc < 0) first_cyc = cyc;
         if (out_vld[g] && out_rdy[g]) got_q.push_back(cur);
         if (gap_on) begin
            if (in_rdy[g]) begin
               n_cmp++;
               if (gap !== pad + 1) begin
                  n_bad++;
                  $display("FAIL %s frame_gap: got %0d want %0d", nm, gap, pad + 1);
               end
               gap_on = 0;
            end else begin
               gap++;
            end
         end
         if (in_vld[g] && in_rdy[g]) begin
            if (idx == trig) acc_cyc = cyc;
            if (chk_gap && (idx % N) == N - 1) begin
               gap_on = 1;
               gap    = 0;
            end
            idx++;
         end
         @(negedge clk);
         cyc++;
      end
      in_vld[g]  = 1'b0;
      out_rdy[g] = 1'b1;
      n_cmp++;
      if (cyc >= 2000) begin
         n_bad++;
         $display("FAIL %s timeout: got %0d windows %0d samples want %0d windows", nm, got_q.size(), idx, exp_q.size());
      end
      n_cmp++;
      if (got_q.size() !== exp_q.size()) begin
         n_bad++;
         $display("FAIL %s count: got %0d want %0d", nm, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i].taps !== exp_q[i].taps) begin
            n_bad++;
            $display("FAIL %s taps[%0d]: got %h want %h", nm, i, got_q[i].taps, exp_q[i].taps);
         end
         n_cmp++;
         if ({got_q[i].first, got_q[i].last} !== {exp_q[i].first, exp_q[i].last}) begin
            n_bad++;
            $display("FAIL %s flags[%0d]: got %b%b want %b%b", nm, i, got_q[i].first, got_q[i].last, exp_q[i].first, exp_q[i].last);
         end
      end
      n_cmp++;
      if (first_cyc !== acc_cyc + 1) begin
         n_bad++;
         $display("FAIL %s latency: got cycle %0d want %0d", nm, first_cyc, acc_cyc + 1);
      end
      repeat (4) @(negedge clk);
      #1;
      n_cmp++;
      if (out_vld[g] !== 1'b0 || in_rdy[g] !== 1'b1) begin
         n_bad++;
         $display("FAIL %s idle: got vld=%b rdy=%b want vld=0 rdy=1", nm, out_vld[g], in_rdy[g]);
      end
      @(negedge clk);
   endtask

   task automatic ramp(output logic [SW-1:0] xs[$], input int base, input int nf);
      xs.delete();
      for (int f = 0; f < nf; f++)
         for (int j = 0; j < N; j++) xs.push_back(SW'(base + 10*f + j));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int g = 0; g < 3; g++) begin
         in_vld[g]  = 1'b0;
         out_rdy[g] = 1'b1;
         data_in[g] = '0;
      end
      repeat (2) @(negedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         n_cmp++;
         if ({out_vld[g], out_first[g], out_last[g], in_rdy[g]} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_ctl[%0d]: got %b want 0000", g, {out_vld[g], out_first[g], out_last[g], in_rdy[g]});
         end
         n_cmp++;
         if (dout[g] !== '0) begin
            n_bad++;
            $display("FAIL reset_data[%0d]: got %h want 0", g, dout[g]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int g = 0; g < 3; g++) begin
         n_cmp++;
         if (in_rdy[g] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_rdy[%0d]: got %b want 1", g, in_rdy[g]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_same_s1();
      logic [SW-1:0] xs[$];
      ramp(xs, 1, 1);
      run_stream(0, xs, 0, 0, -1, 0, 1, "same_s1");
   endtask

   task automatic test_same_s2();
      logic [SW-1:0] xs[$];
      ramp(xs, 1, 1);
      run_stream(1, xs, 0, 0, -1, 0, 1, "same_s2");
   endtask

   task automatic test_valid();
      logic [SW-1:0] xs[$];
      ramp(xs, 1, 1);
      run_stream(2, xs, 0, 0, -1, 0, 1, "valid");
   endtask

   task automatic test_backpressure();
      logic [SW-1:0] xs[$];
      ramp(xs, 1, 1);
      run_stream(0, xs, 0, 0, 2, 5, 1, "backpressure");
   endtask

   task automatic test_back_to_back();
      logic [SW-1:0] xs[$];
      ramp(xs, 1, 2);
      for (int g = 0; g < 3; g++) run_stream(g, xs, 0, 0, -1, 0, 1, "back_to_back");
   endtask

   task automatic test_midframe_reset();
      logic [SW-1:0] xs[$];
      logic [W*SW-1:0] want;
      want = {8'd2, 8'd3, 8'd4};
      out_rdy[0] = 1'b1;
      for (int j = 0; j < 4; j++) begin
         in_vld[0]  = 1'b1;
         data_in[0] = SW'(j + 1);
         @(negedge clk);
      end
      in_vld[0]  = 1'b0;
      out_rdy[0] = 1'b0;
      #1;
      n_cmp++;
      if (out_vld[0] !== 1'b1 || dout[0] !== want) begin
         n_bad++;
         $display("FAIL midreset_pending: got vld=%b win=%h want vld=1 win=%h", out_vld[0], dout[0], want);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_vld[0] !== 1'b0 || dout[0] !== '0 || in_rdy[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_async: got vld=%b win=%h rdy=%b want 0 0 0", out_vld[0], dout[0], in_rdy[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_rdy[0] = 1'b1;
      ramp(xs, 1, 1);
      run_stream(0, xs, 0, 0, -1, 0, 1, "midreset_frame");
   endtask

   task automatic test_random();
      logic [SW-1:0] xs[$];
      for (int r = 0; r < 3; r++) begin
         for (int g = 0; g < 3; g++) begin
            xs.delete();
            for (int j = 0; j < 2*N; j++) xs.push_back(SW'($urandom));
            run_stream(g, xs, 1, 1, -1, 0, 0, "random");
         end
      end
   endtask

   initial begin
      test_reset();
      test_same_s1();
      test_same_s2();
      test_valid();
      test_backpressure();
      test_back_to_back();
      test_midframe_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/windower_stream.md
# windower_stream

Streaming 1-D sliding-window generator for the radio-modulation CNN front end; successor to the serial windower. It accepts frames of `IMG_LEN` multi-channel, multi-bit samples over a valid/ready handshake. It emits one `WINDOW_SIZE`-tap window per output position, with configurable stride and either "same" (zero-padded) or "valid" (unpadded) framing. Full backpressure is supported on both sides, and output windows carry first/last-of-frame flags for the downstream conv engine.

## Interface
- `NO_CH`, 2: channels per sample.
- `DATA_W`, 1: bits per channel.
- `IMG_LEN`, 1024: samples per frame N; N ≥ `WINDOW_SIZE`; any integer, not restricted to powers of 2.
- `WINDOW_SIZE`, 3: taps W; odd, ≥ 1.
- `STRIDE`, 1: output stride S, ≥ 1.
- `PAD_EN`, 1: 1 = same framing with PAD = (W-1)/2 zeros on each side; 0 = valid framing, no padding.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_vld`  in  1  input sample valid.
- `in_rdy`  out  1  block can accept a sample.
- `data_in`  in  NO_CH*DATA_W  sample x[j].
- `out_vld`  out  1  window valid.
- `out_rdy`  in  1  downstream accepts the window.
- `data_out[WINDOW_SIZE-1:0]`  out  NO_CH*DATA_W each  window taps; tap 0 is newest.
- `out_first`  out  1  current window is the first of its frame.
- `out_last`  out  1  current window is the last of its frame.

## Operation
- **Window register:** W-entry shift register `win`. `data_out[k] = win[k]` combinationally.
- **Advance:** one shift of `win`. In RUN, a shift loads `data_in`; in FLUSH, it loads zero.
- **Stall rule:** `adv_ok = !out_vld || out_rdy`. No shift occurs while a window is pending, so `data_out` is stable whenever `out_vld && !out_rdy`.
- **`in_rdy`:** `in_rdy = (state==RUN) && adv_ok && rst_n`. A sample is accepted on `in_vld && in_rdy`.
- **Position counter:** `pos` counts shifts in the current frame, 0 .. N-1+PAD. After shift number `pos` (0-based), the window centre is c = pos - PAD in same mode; in valid mode the window start is s = pos - (W-1).
- **Eligibility:**
  - same mode: `pos ≥ PAD`.
  - valid mode: `pos ≥ W-1` and `pos ≤ N-1`.
- **Stride:** phase counter, mod S, is cleared at the first eligible shift and incremented on each later eligible shift. A window is emitted when the shift is eligible and phase == 0.
- **Emit:** on an emitting shift, `out_vld` is set on the same edge. Otherwise `out_vld` clears when `out_rdy` is high.
- **Window content:**
  - same mode: `data_out[k] = x[c+PAD-k]`; indices outside 0..N-1 read as 0.
  - valid mode: `data_out[k] = x[s+W-1-k]`.
- **Output count per frame:**
  - same mode: (N-1)/S + 1.
  - valid mode: (N-W)/S + 1.
- **Frame flags:** an output counter drives `out_first` (count == 0) and `out_last` (count == total-1). Both are registered with `out_vld`.
- **FSM:**
  - RUN: accept samples. After accepting x[N-1], go to FLUSH if PAD_EN && PAD>0, else go to CLEAR.
  - FLUSH: perform PAD zero shifts, each gated by `adv_ok`. After the last shift, go to CLEAR.
  - CLEAR: wait for `adv_ok`, then zero `win`, `pos`, the phase counter and the output counter, and go to RUN. This guarantees no sample leaks across frames.
- **Counter widths:** `pos` uses $clog2(N+PAD+1) bits; the phase counter uses $clog2(S) bits (minimum 1); the output counter uses $clog2(N+1) bits.
- **Reset (`rst_n` low, asynchronous):**
  - state = RUN; `win`, `pos`, phase and output counters = 0.
  - `out_vld` = `out_first` = `out_last` = 0, so all `data_out` = 0.
  - `in_rdy` = 0 while reset is held.
  - Reset mid-frame discards the partial frame. The first sample after release is x[0] of a new frame.

## Timing
- Latency: the first window appears one cycle after the edge accepting x[PAD] in same mode, or x[W-1] in valid mode.
- Throughput: 1 window/cycle for S=1 with `out_rdy` held high.
- Frame overhead: PAD cycles of flush plus 1 CLEAR cycle. `in_rdy` is low during both.
- `out_rdy` low with `out_vld` high: `in_rdy` drops combinationally in the same cycle. The window, `out_first` and `out_last` hold unchanged.
- Simultaneous `out_rdy` high and an emitting shift: the old window completes and the new window loads on the same edge.

## Test plan
- **Same mode, S=1.** N=8, W=3, x[j]=j+1, `out_rdy`=1 → 8 windows. First = {d0=2, d1=1, d2=0} with `out_first`=1. Last = {0, 8, 7} with `out_last`=1. `in_rdy` is low for 2 cycles (1 flush, 1 clear).
- **Same mode, S=2.** N=8, W=3 → 4 windows, centres 0, 2, 4, 6. Last = {8, 7, 6} with `out_last`=1.
- **Valid mode.** PAD_EN=0, N=8, W=3, S=1 → 6 windows, {3,2,1} .. {8,7,6}. No zero taps, no FLUSH state.
- **Backpressure.** Same config as the first scenario; `out_rdy`=0 for 5 cycles at window 3 → `data_out` is held at {4,3,2}, `in_rdy`=0, no window is lost or duplicated, and the total is still 8.
- **Back-to-back frames.** Frame A = 1..8, then frame B = 11..18 with `in_vld` held high → B's first window is {12, 11, 0}, with no value of A leaking in.
- **Mid-frame reset.** Assert `rst_n` low asynchronously after 4 samples → `out_vld`=0 and `data_out`=0 immediately. After release, a full frame produces 8 correct windows.
